// File: rtl/aes_keygen_pkg.sv
// Shared types, encodings and helpers for the word-serial AES key expander.
package aes_keygen_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NK_W   = 4;
  localparam int unsigned NR_W   = 4;
  localparam int unsigned WIDX_W = 6;
  localparam int unsigned POS_W  = 3;

  localparam logic [1:0] KEYLEN_128 = 2'd0;
  localparam logic [1:0] KEYLEN_192 = 2'd1;
  localparam logic [1:0] KEYLEN_256 = 2'd2;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_e;

  // Encoding 3 falls through to the AES-128 parameters.
  function automatic logic [NK_W-1:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_192: return NK_W'(6);
      KEYLEN_256: return NK_W'(8);
      default:    return NK_W'(4);
    endcase
  endfunction

  function automatic logic [NR_W-1:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_192: return NR_W'(12);
      KEYLEN_256: return NR_W'(14);
      default:    return NR_W'(10);
    endcase
  endfunction

  function automatic logic [WIDX_W-1:0] words_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_192: return WIDX_W'(52);
      KEYLEN_256: return WIDX_W'(60);
      default:    return WIDX_W'(44);
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_word_mem.sv
// Key schedule word store: parallel key load, one word write, two recurrence taps, 4-word round-key read.
module aes_key_word_mem
  import aes_keygen_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned RK_IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    load,
  input  logic [NK_W-1:0]         load_nk,
  input  logic [MAX_KEY_BITS-1:0] load_key,
  input  logic                    we,
  input  logic [WIDX_W-1:0]       waddr,
  input  word_t                   wdata,
  input  logic [WIDX_W-1:0]       prev_addr,
  input  logic [WIDX_W-1:0]       back_addr,
  output word_t                   prev_word,
  output word_t                   back_word,
  input  logic                    rk_en,
  input  logic [RK_IDX_W-1:0]     rk_idx,
  output logic [127:0]            rk_words
);

  localparam int unsigned NUM_WORDS = (MAX_KEY_BITS == 128) ? 44 : 60;
  localparam int unsigned KEY_WORDS = MAX_KEY_BITS / 32;
  localparam int unsigned KW_IDX_W  = $clog2(KEY_WORDS);

  word_t mem_q [NUM_WORDS];
  word_t mem_d [NUM_WORDS];
  word_t [KEY_WORDS-1:0] key_words;
  word_t rk_arr [4];

  assign key_words = load_key;

  // Clear dominates load, load dominates the single-word write.
  always_comb begin
    for (int j = 0; j < NUM_WORDS; j++) mem_d[WIDX_W'(j)] = mem_q[WIDX_W'(j)];
    if (clr) begin
      for (int j = 0; j < NUM_WORDS; j++) mem_d[WIDX_W'(j)] = '0;
    end else if (load) begin
      for (int j = 0; j < KEY_WORDS; j++) begin
        if (NK_W'(j) < load_nk) mem_d[WIDX_W'(j)] = key_words[KW_IDX_W'(KEY_WORDS - 1 - j)];
      end
    end else if (we && (32'(waddr) < NUM_WORDS)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_WORDS; j++) mem_q[WIDX_W'(j)] <= '0;
    end else begin
      for (int j = 0; j < NUM_WORDS; j++) mem_q[WIDX_W'(j)] <= mem_d[WIDX_W'(j)];
    end
  end

  always_comb begin
    prev_word = (32'(prev_addr) < NUM_WORDS) ? mem_q[prev_addr] : '0;
    back_word = (32'(back_addr) < NUM_WORDS) ? mem_q[back_addr] : '0;
  end

  // Words beyond the store, or rounds beyond the current run, read as zero.
  always_comb begin
    int unsigned addr;
    addr = 0;
    for (int k = 0; k < 4; k++) begin
      addr = 32'(rk_idx) * 4 + 32'(k);
      rk_arr[2'(k)] = (rk_en && (addr < NUM_WORDS)) ? mem_q[WIDX_W'(addr)] : '0;
    end
    rk_words = {rk_arr[0], rk_arr[1], rk_arr[2], rk_arr[3]};
  end

endmodule

// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key expansion with shared external S-box.
// Optional AES_KEYGEN_ZEROIZE_EN adds a zeroize input that wipes the schedule.
module aes_key_expander
  import aes_keygen_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned RK_IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef AES_KEYGEN_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic                    init,
  input  logic [1:0]              keyLen,
  input  logic [MAX_KEY_BITS-1:0] key,
  input  logic [RK_IDX_W-1:0]     round,
  output logic [127:0]            roundKey,
  output logic                    ready,
  output logic                    busy,
  output logic [31:0]             beforeSub,
  input  logic [31:0]             afterSub
);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic [1:0]              keylen_q, keylen_d;
  logic [MAX_KEY_BITS-1:0] key_q, key_d;
  logic [WIDX_W-1:0]       idx_q, idx_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [7:0]              rcon_q, rcon_d;

  logic              zero_req;
  logic              mem_clr, mem_load, mem_we;
  word_t             prev_word, back_word, new_word;
  logic [NK_W-1:0]   nk_cur;
  logic [NR_W-1:0]   nr_cur;
  logic [WIDX_W-1:0] words_cur;
  logic              last_pos, sub_pos;

`ifdef AES_KEYGEN_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign nk_cur    = nk_of(keylen_q);
  assign nr_cur    = nr_of(keylen_q);
  assign words_cur = words_of(keylen_q);
  assign last_pos  = (NK_W'(pos_q) == (nk_cur - NK_W'(1)));
  assign sub_pos   = (nk_cur == NK_W'(8)) && (pos_q == POS_W'(4));

  // Next-state and control: single sequencer over IDLE/LOAD/GEN/DONE.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    keylen_d = keylen_q;
    key_d    = key_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    rcon_d   = rcon_q;
    mem_clr  = 1'b0;
    mem_load = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          keylen_d = (MAX_KEY_BITS == 128) ? KEYLEN_128 : keyLen;
          key_d    = key;
          ready_d  = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        mem_load = 1'b1;
        idx_d    = WIDX_W'(nk_cur);
        pos_d    = '0;
        rcon_d   = RCON_INIT;
        state_d  = GEN;
      end
      GEN: begin
        mem_we = 1'b1;
        idx_d  = idx_q + WIDX_W'(1);
        pos_d  = last_pos ? '0 : pos_q + POS_W'(1);
        if (pos_q == '0) rcon_d = xtime(rcon_q);
        if (idx_q == (words_cur - WIDX_W'(1))) state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (zero_req) begin
      mem_clr  = 1'b1;
      mem_load = 1'b0;
      mem_we   = 1'b0;
      ready_d  = 1'b0;
      state_d  = IDLE;
    end
    busy_d = (state_d == LOAD) || (state_d == GEN);
  end

  // Schedule recurrence; afterSub returns SubWord(w[i-1]) in the same cycle.
  always_comb begin
    if (pos_q == '0) begin
      new_word = back_word ^ rot_word(afterSub) ^ {rcon_q, 24'h0};
    end else if (sub_pos) begin
      new_word = back_word ^ afterSub;
    end else begin
      new_word = back_word ^ prev_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      keylen_q <= KEYLEN_128;
      key_q    <= '0;
      idx_q    <= '0;
      pos_q    <= '0;
      rcon_q   <= RCON_INIT;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      keylen_q <= keylen_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      rcon_q   <= rcon_d;
    end
  end

  aes_key_word_mem #(
    .MAX_KEY_BITS(MAX_KEY_BITS),
    .RK_IDX_W    (RK_IDX_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .clr      (mem_clr),
    .load     (mem_load),
    .load_nk  (nk_cur),
    .load_key (key_q),
    .we       (mem_we),
    .waddr    (idx_q),
    .wdata    (new_word),
    .prev_addr(idx_q - WIDX_W'(1)),
    .back_addr(idx_q - WIDX_W'(nk_cur)),
    .prev_word(prev_word),
    .back_word(back_word),
    .rk_en    (32'(round) <= 32'(nr_cur)),
    .rk_idx   (round),
    .rk_words (roundKey)
  );

  assign beforeSub = (state_q == GEN) ? prev_word : '0;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a FIPS-197 style reference expansion.
module tb_aes_key_expander;

  logic         clk;
  logic         reset;
  logic         init;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic         busy;
  logic [31:0]  before_sub;
  logic [31:0]  after_sub;
`ifdef AES_KEYGEN_ZEROIZE_EN
  logic         zeroize;
`endif

  logic [7:0]   sbox [256];
  logic [7:0]   rcon_tab [16];
  logic [31:0]  mw [64];
  int           m_nk, m_nr, m_nw;
  int           checks, errors;
  int           lat;
  logic [255:0] kr, kr2;

  aes_key_expander dut (
    .clk      (clk),
    .reset    (reset),
`ifdef AES_KEYGEN_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .init     (init),
    .keyLen   (key_len),
    .key      (key),
    .round    (round),
    .roundKey (round_key),
    .ready    (ready),
    .busy     (busy),
    .beforeSub(before_sub),
    .afterSub (after_sub)
  );

  // External S-box, combinational.
  assign after_sub = {sbox[before_sub[31:24]], sbox[before_sub[23:16]],
                      sbox[before_sub[15:8]],  sbox[before_sub[7:0]]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map.
  task automatic build_tables;
    logic [7:0] a, inv, s;
    for (int v = 0; v < 256; v++) begin
      a = 8'(v);
      inv = a;
      for (int k = 0; k < 253; k++) inv = gmul(inv, a);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[a] = s;
    end
    for (int k = 0; k < 16; k++) rcon_tab[4'(k)] = 8'h00;
    rcon_tab[1] = 8'h01; rcon_tab[2] = 8'h02; rcon_tab[3]  = 8'h04; rcon_tab[4] = 8'h08;
    rcon_tab[5] = 8'h10; rcon_tab[6] = 8'h20; rcon_tab[7]  = 8'h40; rcon_tab[8] = 8'h80;
    rcon_tab[9] = 8'h1b; rcon_tab[10] = 8'h36;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Textbook key expansion using i mod Nk and i / Nk.
  task automatic model_expand(input logic [1:0] kl, input logic [255:0] k);
    logic [31:0] tmp;
    m_nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    m_nr = m_nk + 6;
    m_nw = 4 * (m_nr + 1);
    for (int j = 0; j < 64; j++) mw[6'(j)] = 32'h0;
    for (int j = 0; j < m_nk; j++) mw[6'(j)] = k[255 - 32 * j -: 32];
    for (int i = m_nk; i < m_nw; i++) begin
      tmp = mw[6'(i - 1)];
      if (i % m_nk == 0)
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[4'(i / m_nk)], 24'h0};
      else if (m_nk > 6 && i % m_nk == 4)
        tmp = subw(tmp);
      mw[6'(i)] = mw[6'(i - m_nk)] ^ tmp;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    if (r > m_nr) return 128'h0;
    return {mw[6'(4 * r)], mw[6'(4 * r + 1)], mw[6'(4 * r + 2)], mw[6'(4 * r + 3)]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse init, then scramble key/keyLen: the captured values must be used.
  task automatic start(input logic [1:0] kl, input logic [255:0] k);
    key_len = kl;
    key     = k;
    init    = 1'b1;
    tick;
    init    = 1'b0;
    key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_len = kl ^ 2'b01;
    chk("load_before_sub", 128'(before_sub), 128'h0);
    chk("busy_in_load", 128'(busy), 128'h1);
    chk("ready_dropped", 128'(ready), 128'h0);
  endtask

  // Count cycles to ready; optional extra init at cycle pulse_at; optional S-box request checks.
  task automatic wait_ready(input int pulse_at, input bit sub_chk, output int cycles);
    int i;
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      tick;
      init = 1'b0;
      if (sub_chk && c <= m_nw - m_nk) begin
        i = m_nk + c - 1;
        if ((i % m_nk == 0) || (m_nk == 8 && i % m_nk == 4))
          chk($sformatf("before_sub_w%0d", i), 128'(before_sub), 128'(mw[6'(i - 1)]));
      end
      if (ready) begin
        cycles = c;
        break;
      end
      if (c == pulse_at) begin
        init    = 1'b1;
        key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_len = 2'd2;
      end
    end
    init = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), round_key, exp_rk(r));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), round_key, 128'h0);
    end
  endtask

  function automatic logic [255:0] rand_key;
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; init = 1'b0; key_len = 2'd0; key = '0; round = '0;
`ifdef AES_KEYGEN_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    build_tables;
    tick; tick;
    reset = 1'b0;
    chk("rst_ready", 128'(ready), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_before_sub", 128'(before_sub), 128'h0);
    check_zero("rst_rk");

    // AES-128 FIPS-197 A.1
    kr = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    model_expand(2'd0, kr);
    start(2'd0, kr);
    wait_ready(-1, 1'b0, lat);
    chk("lat128", 128'(lat), 128'd42);
    round = 4'd1; #1;
    chk("fips128_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    round = 4'd10; #1;
    chk("fips128_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_all("a128");

    // AES-192 FIPS-197 A.2
    kr = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    model_expand(2'd1, kr);
    start(2'd1, kr);
    wait_ready(-1, 1'b0, lat);
    chk("lat192", 128'(lat), 128'd48);
    round = 4'd12; #1;
    chk("fips192_r12", round_key, 128'he98ba06f448c773c8ecc720401002202);
    round = 4'd13; #1;
    chk("fips192_r13", round_key, 128'h0);
    check_all("a192");

    // AES-256 FIPS-197 A.3, with S-box request checks
    kr = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    model_expand(2'd2, kr);
    start(2'd2, kr);
    wait_ready(-1, 1'b1, lat);
    chk("lat256", 128'(lat), 128'd54);
    round = 4'd14; #1;
    chk("fips256_r14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);
    check_all("a256");

    // Extra init during GEN is ignored
    kr = rand_key();
    model_expand(2'd0, kr);
    start(2'd0, kr);
    wait_ready(5, 1'b0, lat);
    chk("lat_ignore_init", 128'(lat), 128'd42);
    check_all("ign");

    // Reset mid-run aborts
    start(2'd2, rand_key());
    repeat (10) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_ready", 128'(ready), 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_before_sub", 128'(before_sub), 128'h0);
    check_zero("abort_rk");

    // Back-to-back 128 then 256 without reset
    kr = rand_key();
    model_expand(2'd0, kr);
    start(2'd0, kr);
    wait_ready(-1, 1'b0, lat);
    chk("b2b_lat128", 128'(lat), 128'd42);
    check_all("b2b128");
    kr2 = rand_key();
    model_expand(2'd2, kr2);
    start(2'd2, kr2);
    wait_ready(-1, 1'b1, lat);
    chk("b2b_lat256", 128'(lat), 128'd54);
    check_all("b2b256");

    // keyLen 3 behaves as AES-128
    model_expand(2'd0, kr);
    start(2'd3, kr);
    wait_ready(-1, 1'b1, lat);
    chk("kl3_lat", 128'(lat), 128'd42);
    check_all("kl3");

    // Random keys across all lengths
    for (int n = 0; n < 2; n++) begin
      for (int kl = 0; kl < 3; kl++) begin
        kr = rand_key();
        model_expand(2'(kl), kr);
        start(2'(kl), kr);
        wait_ready(-1, 1'b1, lat);
        chk($sformatf("rnd_lat_kl%0d", kl), 128'(lat), 128'(2 + m_nw - m_nk));
        check_all($sformatf("rnd%0d_kl%0d", n, kl));
      end
    end

`ifdef AES_KEYGEN_ZEROIZE_EN
    // Zeroize wins over a simultaneous init
    kr = rand_key();
    model_expand(2'd0, kr);
    start(2'd0, kr);
    wait_ready(-1, 1'b0, lat);
    chk("zer_lat", 128'(lat), 128'd42);
    zeroize = 1'b1;
    init    = 1'b1;
    key     = kr;
    key_len = 2'd0;
    tick;
    zeroize = 1'b0;
    init    = 1'b0;
    chk("zer_ready", 128'(ready), 128'h0);
    chk("zer_busy", 128'(busy), 128'h0);
    tick;
    chk("zer_no_start", 128'(busy), 128'h0);
    chk("zer_before_sub", 128'(before_sub), 128'h0);
    check_zero("zer_rk");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
